// File: rtl/vga_pkg.sv
// Timing constants, counter types and phase decode for the 800x600@72Hz VGA raster.
// Shared between the timing generator and the downstream panel pixel stage.
package vga_pkg;

    localparam int   VGA_PIX_DIV  = 2;
    localparam int   VGA_H_ACTIVE = 800;
    localparam int   VGA_H_FP     = 56;
    localparam int   VGA_H_SYNC   = 120;
    localparam int   VGA_H_BP     = 64;
    localparam int   VGA_HTOTAL   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int   VGA_V_ACTIVE = 600;
    localparam int   VGA_V_FP     = 37;
    localparam int   VGA_V_SYNC   = 6;
    localparam int   VGA_V_BP     = 23;
    localparam int   VGA_VTOTAL   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam logic VGA_HS_POL   = 1'b1;
    localparam logic VGA_VS_POL   = 1'b1;

    typedef logic [10:0] hcnt_t;
    typedef logic [9:0]  vcnt_t;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    // Classifies a counter position into the ACTIVE -> FP -> SYNC -> BP sequence of one axis.
    function automatic phase_e phase_of(input int pos, input int act, input int fp, input int sync);
        phase_e ph;
        if (pos < act) begin
            ph = PH_ACTIVE;
        end else if (pos < act + fp) begin
            ph = PH_FP;
        end else if (pos < act + fp + sync) begin
            ph = PH_SYNC;
        end else begin
            ph = PH_BP;
        end
        return ph;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the panel pixel stage.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic  pix_en;
    hcnt_t hcount;
    vcnt_t vcount;
    logic  active;
    logic  hsync;
    logic  vsync;
    logic  line_start;
    logic  frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
`ifdef VGA_TIMING_FRAME_CNT_EN
        output frame_cnt,
`endif
        output pix_en, hcount, vcount, active, hsync, vsync, line_start, frame_start
    );

    modport slave (
`ifdef VGA_TIMING_FRAME_CNT_EN
        input frame_cnt,
`endif
        input pix_en, hcount, vcount, active, hsync, vsync, line_start, frame_start
    );

endinterface

// File: rtl/vga_pix_div.sv
// Pixel clock-enable divider: pix_en_o pulses for one clk every PIX_DIV clks (stuck high for PIX_DIV==1).
// The first pulse appears PIX_DIV clks after reset is released.
module vga_pix_div #(
    parameter int PIX_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en_o
);

    localparam int            CW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q;

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == LAST) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= (div_cnt_q == LAST);
        end
    end

    assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator (800x600@72Hz by default): counters, syncs, blanking, strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   PIX_DIV  = VGA_PIX_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = VGA_HS_POL,
    parameter logic VS_POL   = VGA_VS_POL
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master timing_o
);

    localparam int    HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int    VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam hcnt_t H_LAST = hcnt_t'(HTOTAL - 1);
    localparam vcnt_t V_LAST = vcnt_t'(VTOTAL - 1);

    logic   pix_en;
    hcnt_t  hcount_q, hcount_d;
    vcnt_t  vcount_q, vcount_d;
    phase_e hphase, vphase;
    logic   active_q, hsync_q, vsync_q, line_start_q, frame_start_q;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk      (clk),
        .rst      (rst),
        .pix_en_o (pix_en)
    );

    // Decode from the next-state counters so every registered output lines up with hcount/vcount.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + vcnt_t'(1);
            end else begin
                hcount_d = hcount_q + hcnt_t'(1);
            end
        end
        hphase = phase_of(int'(hcount_d), H_ACTIVE, H_FP, H_SYNC);
        vphase = phase_of(int'(vcount_d), V_ACTIVE, V_FP, V_SYNC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            active_q      <= (hphase == PH_ACTIVE) && (vphase == PH_ACTIVE);
            hsync_q       <= (hphase == PH_SYNC) ? HS_POL : ~HS_POL;
            vsync_q       <= (vphase == PH_SYNC) ? VS_POL : ~VS_POL;
            line_start_q  <= (hcount_d == '0);
            frame_start_q <= (hcount_d == '0) && (vcount_d == '0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;
    logic        frame_wrap;

    // Counts only real wraps, so the frame started by reset release reads 0.
    assign frame_wrap = pix_en && (hcount_q == H_LAST) && (vcount_q == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign timing_o.frame_cnt = frame_cnt_q;
`endif

    assign timing_o.pix_en      = pix_en;
    assign timing_o.hcount      = hcount_q;
    assign timing_o.vcount      = vcount_q;
    assign timing_o.active      = active_q;
    assign timing_o.hsync       = hsync_q;
    assign timing_o.vsync       = vsync_q;
    assign timing_o.line_start  = line_start_q;
    assign timing_o.frame_start = frame_start_q;

endmodule
